aes_inv_sub_shift: RTL
======================

AES_INV_SUB_SHIFT -- requirements
Module: aes_inv_sub_shift

Interface
REQ-001 SHALL have parameter: LANES, default 1, inverse S-box lookups per cycle; legal values 1, 2, 4, 16.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block accepts in_state.
- in_state  in  128  input state; byte b at [127-8b -: 8]; byte b = row b%4, column b/4.
- out_valid  out  1  out_state holds a complete result.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  InvSubBytes(InvShiftRows(in_state)); same byte order as in_state.
- busy  out  1  high in BUSY.

Function
REQ-003 SHALL compute out byte 4c+r = InvSbox(in byte 4*((c-r) mod 4)+r), for r,c in 0..3.
REQ-004 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-005 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, and busy=1 only in BUSY.
REQ-006 SHALL, in IDLE with in_valid=1, capture in_state into an internal 128-bit register, clear the byte counter, and enter BUSY.
REQ-007 SHALL, in each BUSY cycle, write LANES output bytes, indices counter..counter+LANES-1, then add LANES to the counter.
REQ-008 SHALL move to DONE on the edge that writes byte 15, so latency from the accept edge to the edge asserting out_valid is 16/LANES cycles.
REQ-009 SHALL size the byte counter at 4 bits; it SHALL wrap to 0 on the final write, with no out-of-range index.
REQ-010 SHALL hold out_state and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-011 SHALL take no new input while in BUSY or DONE; in_valid there has no effect and the captured register stays unchanged.
REQ-012 SHALL NOT accept a new input on the same edge as the DONE-to-IDLE handshake; the minimum issue interval is 16/LANES+2 cycles.
REQ-013 SHALL treat out_ready as don't-care outside DONE.
REQ-014 SHALL keep out_state equal to its previous value, or zero after reset, for all bytes not yet rewritten during BUSY; consumers must only sample when out_valid=1.
REQ-015 SHALL be purely byte-substitution/permutation, with no key addition and no InvMixColumns.

Reset
REQ-016 SHALL, while rst=1 and independent of clk, force: state=IDLE, counter=0, captured register=0, out_state=0, out_valid=0, busy=0, in_ready=1.
REQ-017 SHALL, on rst during BUSY or DONE, discard the operation with no partial output flagged valid; the first accept after reset release starts a clean operation.

Structure
REQ-018 SHALL place the FSM state encodings and the legal-LANES check in a shared package, aes_pkg; an illegal LANES SHALL stop elaboration.
REQ-019 SHALL instantiate LANES copies of one sub-module, aes_inv_sbox: 8-bit in_byte, 8-bit out_byte, combinational 256-entry inverse Rijndael LUT.
REQ-020 SHALL keep all registers in this module and none in aes_inv_sbox.

Verification
REQ-021 SHALL cover FIPS-197 C.1 inverse round 1, LANES=1: in_state=7ad5fda789ef4e272bca100b3d9ff59f -> out_state=bd6e7c3df2b5779e0b61216e8b10b689, out_valid exactly 16 cycles after the accept edge.
REQ-022 SHALL cover LANES=4 and LANES=16 with the vector of REQ-021 -> same out_state; out_valid at 4 and 1 cycles respectively.
REQ-023 SHALL cover in_state=63636363...63 (all 0x63) -> out_state=00000000...00; in_state=16161616...16 -> ffffffff...ff.
REQ-024 SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held high and a different in_state -> out_state unchanged, in_ready=0, second input accepted only in the cycle after the handshake.
REQ-025 SHALL cover rst pulsed at BUSY cycle 7 -> all outputs at reset values immediately (asynchronous); a following input produces the correct result with the full latency.
REQ-026 SHALL cover an exhaustive aes_inv_sbox unit check: for all x in 00..ff, the forward Rijndael S-box applied to InvSbox(x) equals x; spot values 00->52, 63->00, 7c->01.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the inverse SubBytes/ShiftRows block: FSM encoding,
// LANES legality and the InvShiftRows byte mapping.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 16);
   endfunction

   // Destination byte 4c+r takes source byte 4*((c-r) mod 4)+r; the 2-bit
   // subtraction provides the mod 4 for free.
   function automatic logic [3:0] src_index(input logic [3:0] dst);
      logic [1:0] src_col;
      src_col = dst[3:2] - dst[1:0];
      return {src_col, dst[1:0]};
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: 256-entry lookup, no state.
module aes_inv_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_shift.sv
// InvSubBytes(InvShiftRows(state)) computed LANES bytes per cycle behind a
// valid/ready handshake on both sides.
module aes_inv_sub_shift
   import aes_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $fatal(1, "aes_inv_sub_shift: LANES must be 1, 2, 4 or 16");
   end

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] cap_q, cap_d;
   logic [127:0] out_q, out_d;

   logic [3:0]   lane_idx [LANES];
   logic [7:0]   sbox_in  [LANES];
   logic [7:0]   sbox_out [LANES];

   // LANES divides 16 and the counter advances in steps of LANES, so
   // cnt_q + l never carries out of 4 bits.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l] = cnt_q + 4'(l);
         sbox_in[l]  = cap_q[127 - 8*int'(src_index(lane_idx[l])) -: 8];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_inv_sbox u_inv_sbox (
         .in_byte  (sbox_in[l]),
         .out_byte (sbox_out[l])
      );
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise a latch would be inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      out_d   = out_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               cap_d   = in_state;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int l = 0; l < LANES; l++) begin
               out_d[127 - 8*int'(lane_idx[l]) -: 8] = sbox_out[l];
            end
            // Truncation makes the counter wrap to 0 on the final write.
            cnt_d = cnt_q + 4'(LANES);
            if (cnt_q == 4'(16 - LANES)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the data registers are reset too, so a discarded operation can
      // never leave stale bytes visible on out_state after reset.
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         out_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_BUSY);
   assign out_state = out_q;

endmodule
